// File: rtl/sdspi_word_loader_if.sv
// Memory write bus for the SD-card word loader.
// The loader drives the request; memory answers with wr_ready.
interface sdspi_word_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sdspi_word_loader.sv
// Packs the SD file byte stream into words and writes them to memory.
// Words pass through a small show-ahead FIFO; the tail word is padded.
module sdspi_word_loader #(
    parameter int              DATA_W     = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              MAX_BYTES  = 65536,
    parameter int              BIG_ENDIAN = 0,
    parameter logic [7:0]      PAD_BYTE   = 8'h00
) (
    input  logic        clk27mhz,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    sdspi_word_loader_if.master wr,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [31:0] bytes_loaded
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [IDX_W-1:0] KLAST = IDX_W'(NB - 1);
    localparam logic [31:0]      MAXB  = 32'(MAX_BYTES);
    localparam logic [AW:0]      FULLN = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    typedef logic [NB-1:0][7:0] word_t;

    state_t           state;
    logic [IDX_W-1:0] k;
    word_t            pack;

    word_t            mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [ADDR_W-1:0] addr;

    logic  arm;
    logic  accept;
    logic  push_req;
    logic  do_push;
    logic  pop;
    logic  full;
    word_t word_now;
    word_t pad_word;
    word_t push_word;

    // Lane order: little-endian fills upward, big-endian from the top.
    function automatic logic [IDX_W-1:0] lane_of(input logic [IDX_W-1:0] j);
        return (BIG_ENDIAN != 0) ? (KLAST - j) : j;
    endfunction

    assign wr.wr_valid = (count != '0);
    assign wr.wr_data  = mem[rptr];
    assign wr.wr_addr  = addr;

    assign pop     = wr.wr_valid && wr.wr_ready;
    assign full    = (count == FULLN);
    assign do_push = push_req && (!full || pop);
    assign arm     = start && (state == S_IDLE || state == S_DONE);

    // Byte acceptance, word assembly and tail padding.
    always_comb begin
        accept = (state == S_LOAD) && in_valid && (bytes_loaded < MAXB);
        word_now = pack;
        word_now[lane_of(k)] = in_byte;
        pad_word = pack;
        for (int j = 0; j < NB; j++) begin
            if (j >= int'(k)) begin
                pad_word[lane_of(IDX_W'(j))] = PAD_BYTE;
            end
        end
        push_req  = 1'b0;
        push_word = word_now;
        if (accept && k == KLAST) begin
            push_req = 1'b1;
        end else if (state == S_FLUSH && k != '0) begin
            push_req  = 1'b1;
            push_word = pad_word;
        end
    end

    // Load sequencing: arm, pack bytes, flush the tail, report status.
    always_ff @(posedge clk27mhz) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            bytes_loaded <= '0;
            k            <= '0;
            pack         <= '0;
        end else begin
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        overflow     <= 1'b0;
                        bytes_loaded <= '0;
                        k            <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        pack         <= word_now;
                        bytes_loaded <= bytes_loaded + 32'd1;
                        k            <= (k == KLAST) ? '0 : k + 1'b1;
                    end
                    if (in_last || bytes_loaded >= MAXB ||
                        (accept && bytes_loaded + 32'd1 == MAXB)) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (k != '0) begin
                        k <= '0;
                    end else if (count == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Word FIFO and write address; a full push is dropped unless popped.
    always_ff @(posedge clk27mhz) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            addr  <= BASE_ADDR;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= push_word;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (!do_push && pop) begin
                count <= count - 1'b1;
            end
            if (arm) begin
                addr <= BASE_ADDR;
            end else if (pop) begin
                addr <= addr + ADDR_W'(NB);
            end
        end
    end
endmodule

// File: doc/sdspi_word_loader.md
Name: sdspi_word_loader

Overview:
- Generalised successor to the SD-card boot-image loader.
- Takes the byte stream from the SD file reader and packs it into DATA_W-bit words, with selectable byte order.
- Words go through a small FIFO and are written to memory over a valid/ready handshake, at incrementing addresses starting at BASE_ADDR.
- Stops at end-of-file or at MAX_BYTES, pads the final partial word, and reports done, overflow and byte count.

Parameters:
- DATA_W, 32, output word width in bits; multiple of 8, range 8..128; NB = DATA_W/8.
- FIFO_DEPTH, 4, word FIFO depth; power of 2, at least 2.
- ADDR_W, 32, write address width.
- BASE_ADDR, 0, address of the first word written.
- MAX_BYTES, 65536, byte limit; bytes beyond it are ignored; must be at least 1.
- BIG_ENDIAN, 0, 0 = first byte goes to bits [7:0]; 1 = first byte goes to the top byte.
- PAD_BYTE, 8'h00, fill value for the unused bytes of the final partial word.

Ports:
- clk27mhz, in, 1, system clock.
- rst, in, 1, synchronous reset, active-high.
- start, in, 1, one-cycle pulse that arms a load.
- in_valid, in, 1, byte strobe from the file reader.
- in_byte, in, 8, file byte.
- in_last, in, 1, end of file; qualified by in_valid (marks the last byte) or asserted alone (EOF with no byte).
- wr_valid, out, 1, write request.
- wr_addr, out, ADDR_W, write address.
- wr_data, out, DATA_W, packed word.
- wr_ready, in, 1, memory accepts the write this cycle.
- busy, out, 1, high in LOAD or FLUSH.
- done, out, 1, load complete; held until start or rst.
- overflow, out, 1, sticky; a completed word was dropped because the FIFO was full.
- bytes_loaded, out, 32, bytes accepted in this load.

Behaviour:
- Reset: state IDLE; wr_valid, busy, done, overflow = 0; bytes_loaded = 0; wr_addr = BASE_ADDR; wr_data = 0; FIFO emptied; pack index = 0. rst mid-load discards the FIFO and any partial word; no write is issued after the rst cycle.
- IDLE/DONE + start: go to LOAD and clear bytes_loaded, overflow, done and the pack index. Set the address to BASE_ADDR.
- start during LOAD or FLUSH is ignored.
- in_valid and in_last are ignored outside LOAD.
- LOAD, byte accepted when in_valid=1 and bytes_loaded < MAX_BYTES:
  - write the byte into lane k (BIG_ENDIAN selects lane order);
  - k = k+1, wrapping to 0 after NB-1;
  - bytes_loaded = bytes_loaded + 1.
- When lane NB-1 is written, push the completed word into the FIFO in that same cycle.
- FIFO full at push:
  - if a pop happens in the same cycle, the push succeeds;
  - otherwise the word is dropped, overflow = 1, and bytes_loaded still counts the bytes.
- End condition, whichever comes first:
  - in_last=1 in LOAD; if in_valid is also high, its byte is taken first;
  - bytes_loaded reaching MAX_BYTES.
  - Then go to FLUSH.
- FLUSH:
  - if k != 0, fill lanes k..NB-1 with PAD_BYTE and push the word (same full/drop rule as LOAD);
  - wait until the FIFO is empty, then go to DONE with done = 1 and busy = 0.
- An empty file (in_last with no bytes) completes with no writes and bytes_loaded = 0.
- Output side: wr_valid = FIFO not empty; wr_data = FIFO head (show-ahead).
- Pop and wr_addr update occur when wr_valid and wr_ready are both high: wr_addr += NB, wrapping modulo 2^ADDR_W.
- wr_data and wr_addr stay stable while wr_valid=1 and wr_ready=0.
- Latency: the byte that completes a word into an empty FIFO at cycle t gives wr_valid=1 at t+1.
- Throughput: one word per cycle when wr_ready stays high.
- Simultaneous push and pop on an empty FIFO: the pushed word appears at t+1; no bypass.
- bytes_loaded never exceeds MAX_BYTES; it saturates at that value, and in_valid is ignored once it is reached.

Test Plan:
- DATA_W=32, BIG_ENDIAN=0, bytes 11 22 33 44 55 66 77 88, in_last with 88, wr_ready=1 → writes 44332211 @0 and 88776655 @4; done=1; bytes_loaded=8; overflow=0.
- Same stream with BIG_ENDIAN=1 and BASE_ADDR=0x100 → 11223344 @0x100, 55667788 @0x104.
- 5 bytes AA BB CC DD EE, in_last on EE, PAD_BYTE=00 → DDCCBBAA @0, then 000000EE @4; done after the second handshake.
- FIFO_DEPTH=2, wr_ready=0 while 12 bytes arrive, then wr_ready=1 → exactly 2 writes (words 0 and 1), overflow=1, bytes_loaded=12, done=1.
- MAX_BYTES=6, 10 bytes streamed, no in_last → 2 writes (second padded as 0000xxxx), bytes_loaded=6, bytes 7..10 ignored.
- rst pulsed after 3 words are queued with wr_ready=0 → next cycle wr_valid=0, wr_addr=BASE_ADDR, bytes_loaded=0; after a new start the first write goes to BASE_ADDR.
